// File: rtl/prog_loader_pkg.sv
// ============================================================================
//  Module      : prog_loader_pkg
//  Description : Shared types and constants for the runtime program loader.
//                Optional feature macro: PROG_LOADER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

    // Width of the frame length field (LEN_LO + LEN_HI)
    localparam int LEN_W = 16;

    // Default frame start byte
    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    // Loader FSM states; CSUM only exists when the checksum is built in
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CSUM   = 3'd4,
`endif
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/loader_byte_packer.sv
// ============================================================================
//  Module      : loader_byte_packer
//  Description : Packs a little-endian byte stream into 32-bit words. The
//                incoming fourth byte completes the word combinationally so
//                the word is available in the same cycle it is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  cnt;
    logic [23:0] hold;   // bytes 0..2 of the word in progress, newest on top

    // Byte counter and holding register; cleared at frame start or abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 2'd0;
            hold <= 24'd0;
        end else if (clear) begin
            cnt  <= 2'd0;
            hold <= 24'd0;
        end else if (byte_valid) begin
            cnt  <= cnt + 2'd1;
            hold <= {byte_data, hold[23:8]};
        end
    end

    assign word_valid = byte_valid && (cnt == 2'd3);
    assign word_data  = {byte_data, hold};

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
//  Module      : prog_loader
//  Description : Receives a framed byte stream (MAGIC, LEN_LO, LEN_HI,
//                payload[, XOR checksum]) and writes it into IMEM while
//                holding the core in reset until a valid image is loaded.
//                Optional feature macro: PROG_LOADER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         IMEM_DEPTH = 1024,
    parameter logic [7:0] MAGIC      = MAGIC_DEFAULT,
    localparam int        AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          restart,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_hold,
    output logic          done,
    output logic          err
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(IMEM_DEPTH);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam loader_state_e ST_TAIL = ST_CSUM;
`else
    localparam loader_state_e ST_TAIL = ST_DONE;
`endif

    loader_state_e    state, state_nxt;
    logic [7:0]       len_lo;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_in;
    logic [AW-1:0]    word_idx;
    logic             accept;
    logic             frame_start;
    logic             data_byte;
    logic             last_word;
    logic             word_valid;
    logic [31:0]      word_data;

    // restart wins over a simultaneous handshake: that byte is dropped
    assign accept      = in_valid && in_ready && !restart;
    assign frame_start = accept && (state == ST_IDLE) && (in_data == MAGIC);
    assign data_byte   = accept && (state == ST_DATA);
    assign len_in      = {in_data, len_lo};
    assign last_word   = word_valid && (LEN_W'(word_idx) == len - LEN_W'(1));

    loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (restart || frame_start),
        .byte_valid (data_byte),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR over payload bytes, restarted with each frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= 8'd0;
        end else if (restart || frame_start) begin
            csum <= 8'd0;
        end else if (data_byte) begin
            csum <= csum ^ in_data;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; non-MAGIC bytes in IDLE are silently discarded
    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (frame_start) state_nxt = ST_LEN_LO;
                ST_LEN_LO: if (accept)      state_nxt = ST_LEN_HI;
                ST_LEN_HI: begin
                    if (accept) begin
                        if (len_in > DEPTH_L)         state_nxt = ST_ERR;
                        else if (len_in == '0)        state_nxt = ST_TAIL;
                        else                          state_nxt = ST_DATA;
                    end
                end
                ST_DATA:   if (last_word)   state_nxt = ST_TAIL;
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (accept) state_nxt = (in_data == csum) ? ST_DONE : ST_ERR;
                end
`endif
                ST_DONE:   state_nxt = ST_DONE;
                ST_ERR:    state_nxt = ST_ERR;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Registered status outputs, derived from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            core_hold <= 1'b1;
        end else begin
            in_ready  <= (state_nxt != ST_DONE) && (state_nxt != ST_ERR);
            done      <= (state_nxt == ST_DONE);
            err       <= (state_nxt == ST_ERR);
            core_hold <= (state_nxt != ST_DONE);
        end
    end

    // Length capture and word index; the length check keeps word_idx in range
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo   <= 8'd0;
            len      <= '0;
            word_idx <= '0;
        end else begin
            if (accept && (state == ST_LEN_LO)) len_lo <= in_data;
            if (accept && (state == ST_LEN_HI)) len    <= len_in;
            if (restart || frame_start) begin
                word_idx <= '0;
            end else if (word_valid) begin
                word_idx <= word_idx + AW'(1);
            end
        end
    end

    // IMEM write port: one-cycle strobe after the word's fourth byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= word_valid;
            if (word_valid) begin
                imem_addr  <= word_idx;
                imem_wdata <= word_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader with randomized byte
//                gaps and images, checked against a frame-level model.
//                Honours PROG_LOADER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

    localparam int DEPTH = 1024;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        restart;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] img[$];       // image words of the frame being sent
    logic [31:0] wq_addr[$];   // observed IMEM writes
    logic [31:0] wq_data[$];

    always #5 clk = ~clk;

    prog_loader #(.IMEM_DEPTH(DEPTH), .MAGIC(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .err        (err)
    );

    // Record every IMEM write, as an attached memory would see it
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wq_addr.push_back({22'd0, imem_addr});
            wq_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present one byte (after an optional random gap) and wait for the handshake
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic restart_pulse(input string tag);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        @(negedge clk);
        check({tag, "_rs_ready"}, {31'd0, in_ready},  32'd1);
        check({tag, "_rs_hold"},  {31'd0, core_hold}, 32'd1);
        check({tag, "_rs_done"},  {31'd0, done},      32'd0);
        check({tag, "_rs_err"},   {31'd0, err},       32'd0);
        @(posedge clk);
        #1;
    endtask

    // Send a whole frame built from img and compare outcome with the model
    task automatic run_frame(input int len, input bit csum_ok, input string tag);
        logic [7:0] x = 8'd0;
        bit exp_err;
        bit len_bad;
        int nwords;
        wq_addr.delete();
        wq_data.delete();
        len_bad = (len > DEPTH);
        exp_err = len_bad;
        send_byte(8'hA5);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        if (!len_bad) begin
            foreach (img[i]) begin
                for (int k = 0; k < 4; k++) begin
                    send_byte(img[i][8*k +: 8]);
                    x ^= img[i][8*k +: 8];
                end
            end
            if (CSUM_EN) begin
                send_byte(csum_ok ? x : (x ^ 8'h5A));
                exp_err = !csum_ok;
            end
        end
        // Final byte was accepted on the previous edge: status must already show
        @(negedge clk);
        check({tag, "_done"},  {31'd0, done},      {31'd0, !exp_err});
        check({tag, "_err"},   {31'd0, err},       {31'd0, exp_err});
        check({tag, "_hold"},  {31'd0, core_hold}, {31'd0, exp_err});
        check({tag, "_ready"}, {31'd0, in_ready},  32'd0);
        repeat (2) @(posedge clk);
        #1;
        nwords = len_bad ? 0 : img.size();
        check({tag, "_nwr"}, wq_addr.size(), nwords);
        for (int i = 0; i < nwords && i < wq_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wq_addr[i], i);
            check($sformatf("%s_data%0d", tag, i), wq_data[i], img[i]);
        end
    endtask

    task automatic random_image(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = 8'd0;
        in_valid = 1'b0;
        restart  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, in_ready},  32'd0);
        check("rst_we",    {31'd0, imem_we},   32'd0);
        check("rst_addr",  {22'd0, imem_addr}, 32'd0);
        check("rst_wdata", imem_wdata,         32'd0);
        check("rst_hold",  {31'd0, core_hold}, 32'd1);
        check("rst_done",  {31'd0, done},      32'd0);
        check("rst_err",   {31'd0, err},       32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_pre", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("ready_rise", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Garbage before the frame is ignored
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        @(negedge clk);
        check("garbage_err",  {31'd0, err},  32'd0);
        check("garbage_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;

        img = '{32'h00500093, 32'h00700113, 32'h002081B3};
        run_frame(3, 1'b1, "prog1");

        restart_pulse("ovf");
        img.delete();
        run_frame(DEPTH + 1, 1'b1, "ovf");

        restart_pulse("len0");
        img.delete();
        run_frame(0, 1'b1, "len0");

        // Abort a partial frame, then load a fresh one
        restart_pulse("abort");
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        restart_pulse("abort2");
        random_image(2);
        run_frame(2, 1'b1, "abort");

        // Random images; each overwrites address 0 of the previous one
        for (int r = 0; r < 4; r++) begin
            restart_pulse($sformatf("rnd%0d", r));
            random_image($urandom_range(1, 6));
            run_frame(img.size(), (r != 2), $sformatf("rnd%0d", r));
        end

        // Reset in the middle of DATA, then resend the whole frame
        restart_pulse("mid");
        random_image(4);
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h00);
        for (int k = 0; k < 6; k++) send_byte(img[k / 4][8*(k % 4) +: 8]);
        rst = 1'b1;
        #1;
        check("mid_ready", {31'd0, in_ready},  32'd0);
        check("mid_we",    {31'd0, imem_we},   32'd0);
        check("mid_addr",  {22'd0, imem_addr}, 32'd0);
        check("mid_wdata", imem_wdata,         32'd0);
        check("mid_hold",  {31'd0, core_hold}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(4, 1'b1, "resend");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
